// File: rtl/rom_burst_sync_pkg.sv
// rtl/rom_burst_sync_pkg.sv - shared types for the burst program ROM
// Contents: FSM state encoding and the burst counter width helper.
package rom_burst_sync_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rom_state_e;

  // Counter must be able to hold BURST_LEN itself, hence the +1.
  function automatic int burst_cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/rom_read_pipe.sv
// rtl/rom_read_pipe.sv - LATENCY-stage output register for {valid, err, data}
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset, clears every stage
//   valid_i in   a beat enters the pipe this cycle
//   err_i   in   beat carries an out-of-range flag
//   data_i  in   beat data
//   valid_o out  beat leaves the pipe
//   err_o   out  error flag, only ever high together with valid_o
//   data_o  out  beat data, holds its last value while valid_o is low
module rom_read_pipe #(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              err_o,
  output logic [DATA_W-1:0] data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] err_q;
  logic [DATA_W-1:0]  data_q [LATENCY];

  // Data registers only load on a valid beat so each stage holds its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= valid_i & err_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign err_o   = err_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/rom_burst_sync.sv
// rtl/rom_burst_sync.sv - parametrised synchronous program ROM with burst fetch
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   rd_req     in   read request, accepted when busy is low
//   burst      in   with rd_req: 1 = BURST_LEN-word burst, 0 = single word
//   address    in   start address, sampled on acceptance only
//   data_out   out  read data, holds while data_valid is low
//   data_valid out  data_out carries a new word this cycle
//   addr_err   out  beat address was >= DEPTH (data_out = FILL_VALUE)
//   busy       out  burst in progress, rd_req ignored
// INIT_RAMP = 1 fills word i with i+1; otherwise the image is all zeros.
module rom_burst_sync #(
  parameter int              DATA_W     = 8,
  parameter int              ADDR_W     = 8,
  parameter int              DEPTH      = 128,
  parameter int              LATENCY    = 1,
  parameter int              BURST_LEN  = 4,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0,
  parameter bit              INIT_RAMP  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              burst,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              addr_err,
  output logic              busy
);

  import rom_burst_sync_pkg::*;

  localparam int              CNT_W   = burst_cnt_w(BURST_LEN);
  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef logic [DATA_W-1:0] word_t;

  // ROM image
  word_t rom_mem [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom_mem[g] = INIT_RAMP ? word_t'(g + 1) : '0;
  end

  rom_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] start_q, start_d;

  // Issue stage: the beat selected at an edge, looked up in the ROM next cycle.
  logic              iss_valid_q, iss_valid_d;
  logic              iss_err_q, iss_err_d;
  logic [IDX_W-1:0]  iss_idx_q, iss_idx_d;

  logic [ADDR_W:0]   sum;
  logic [IDX_W-1:0]  wrap_idx;
  logic              start_bad;
  word_t             rd_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = start_q;
    iss_valid_d = 1'b0;
    iss_err_d   = 1'b0;
    iss_idx_d   = '0;
    // One extra bit keeps the carry; start < DEPTH and cnt < DEPTH so a single
    // conditional subtract is a complete mod-DEPTH reduction.
    sum       = {1'b0, start_q} + (ADDR_W+1)'(cnt_q);
    wrap_idx  = (sum >= DEPTH_X) ? IDX_W'(sum - DEPTH_X) : IDX_W'(sum);
    start_bad = ({1'b0, address} >= DEPTH_X);

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          iss_valid_d = 1'b1;
          iss_err_d   = start_bad;
          iss_idx_d   = start_bad ? '0 : address[IDX_W-1:0];
          // A bad start address aborts the burst after its single error beat.
          if (burst && !start_bad) begin
            state_d = ST_BURST;
            cnt_d   = CNT_W'(1);
            start_d = address;
          end
        end
      end
      ST_BURST: begin
        iss_valid_d = 1'b1;
        iss_idx_d   = wrap_idx;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      start_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_err_q   <= 1'b0;
      iss_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      iss_valid_q <= iss_valid_d;
      iss_err_q   <= iss_err_d;
      iss_idx_q   <= iss_idx_d;
    end
  end

  // Error beats never touch the array.
  assign rd_data = iss_err_q ? FILL_VALUE : rom_mem[iss_idx_q];
  assign busy    = (state_q == ST_BURST);

  rom_read_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .valid_i (iss_valid_q),
    .err_i   (iss_err_q),
    .data_i  (rd_data),
    .valid_o (data_valid),
    .err_o   (addr_err),
    .data_o  (data_out)
  );

endmodule

// File: tb/tb_rom_burst_sync.sv
// tb/tb_rom_burst_sync.sv - bench for rom_burst_sync at LATENCY 1 and 2
module tb_rom_burst_sync;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rd_req = 1'b0;
  logic       burst = 1'b0;
  logic [7:0] address = 8'h00;

  logic [7:0] d1, d2;
  logic       v1, v2, e1, e2, b1, b2;

  always #5 clk = ~clk;

  rom_burst_sync #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(128), .LATENCY(1), .BURST_LEN(4),
    .FILL_VALUE(8'hEE), .INIT_RAMP(1'b1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .rd_req(rd_req), .burst(burst), .address(address),
    .data_out(d1), .data_valid(v1), .addr_err(e1), .busy(b1)
  );

  rom_burst_sync #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(128), .LATENCY(2), .BURST_LEN(4),
    .FILL_VALUE(8'hEE), .INIT_RAMP(1'b1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .rd_req(rd_req), .burst(burst), .address(address),
    .data_out(d2), .data_valid(v2), .addr_err(e2), .busy(b2)
  );

  typedef struct {
    logic       req;
    logic       bst;
    logic [7:0] addr;
    logic       v;
    logic       e;
    logic [7:0] d;
    logic       busy;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic r, input logic b, input logic [7:0] a,
                      input logic v, input logic e, input logic [7:0] d, input logic bz);
    vecs[i] = '{r, b, a, v, e, d, bz};
  endtask

  task automatic drive(input logic r, input logic b, input logic [7:0] a);
    rd_req  = r;
    burst   = b;
    address = a;
  endtask

  logic       p_v, p_e;
  logic [7:0] p_d;

  initial begin
    // Expected columns describe outputs after the edge that samples the row's inputs.
    //        req bst addr   v  e  data  busy
    setv( 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    setv( 1, 1, 0, 8'h00, 0, 0, 8'h00, 0);  // singles 0..4
    setv( 2, 1, 0, 8'h01, 1, 0, 8'h01, 0);
    setv( 3, 1, 0, 8'h02, 1, 0, 8'h02, 0);
    setv( 4, 1, 0, 8'h03, 1, 0, 8'h03, 0);
    setv( 5, 1, 0, 8'h04, 1, 0, 8'h04, 0);
    setv( 6, 0, 0, 8'h00, 1, 0, 8'h05, 0);
    setv( 7, 0, 0, 8'h00, 0, 0, 8'h05, 0);  // data holds
    setv( 8, 1, 1, 8'h10, 0, 0, 8'h05, 1);  // burst at 10
    setv( 9, 1, 0, 8'h00, 1, 0, 8'h11, 1);  // dropped while busy
    setv(10, 1, 1, 8'h20, 1, 0, 8'h12, 1);  // dropped while busy
    setv(11, 0, 0, 8'h00, 1, 0, 8'h13, 0);
    setv(12, 1, 0, 8'h05, 1, 0, 8'h14, 0);  // first cycle busy low
    setv(13, 0, 0, 8'h00, 1, 0, 8'h06, 0);  // no gap
    setv(14, 1, 1, 8'h7E, 0, 0, 8'h06, 1);  // wrapping burst
    setv(15, 0, 0, 8'h00, 1, 0, 8'h7F, 1);
    setv(16, 0, 0, 8'h00, 1, 0, 8'h80, 1);
    setv(17, 0, 0, 8'h00, 1, 0, 8'h01, 0);
    setv(18, 0, 0, 8'h00, 1, 0, 8'h02, 0);
    setv(19, 0, 0, 8'h00, 0, 0, 8'h02, 0);
    setv(20, 1, 0, 8'h80, 0, 0, 8'h02, 0);  // first illegal address
    setv(21, 1, 1, 8'hE0, 1, 1, 8'hEE, 0);  // bad burst start
    setv(22, 0, 0, 8'h00, 1, 1, 8'hEE, 0);
    setv(23, 1, 0, 8'h7F, 0, 0, 8'hEE, 0);  // last legal address
    setv(24, 0, 0, 8'h00, 1, 0, 8'h80, 0);
    setv(25, 0, 0, 8'h00, 0, 0, 8'h80, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid1", 0, {7'd0, v1}, 8'h00);
    chk("rst_data1",  0, d1, 8'h00);
    chk("rst_busy1",  0, {7'd0, b1}, 8'h00);
    chk("rst_valid2", 0, {7'd0, v2}, 8'h00);
    chk("rst_data2",  0, d2, 8'h00);
    reset = 1'b1;

    p_v = 1'b0; p_e = 1'b0; p_d = 8'h00;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].req, vecs[i].bst, vecs[i].addr);
      @(posedge clk);
      @(negedge clk);
      chk("l1_valid", i, {7'd0, v1}, {7'd0, vecs[i].v});
      chk("l1_err",   i, {7'd0, e1}, {7'd0, vecs[i].e});
      chk("l1_data",  i, d1, vecs[i].d);
      chk("l1_busy",  i, {7'd0, b1}, {7'd0, vecs[i].busy});
      // LATENCY 2 shows the same beats one cycle later; busy is unaffected.
      chk("l2_valid", i, {7'd0, v2}, {7'd0, p_v});
      chk("l2_err",   i, {7'd0, e2}, {7'd0, p_e});
      chk("l2_data",  i, d2, p_d);
      chk("l2_busy",  i, {7'd0, b2}, {7'd0, vecs[i].busy});
      p_v = vecs[i].v; p_e = vecs[i].e; p_d = vecs[i].d;
    end

    // Reset mid-burst: outputs clear at once, nothing stale afterwards.
    drive(1'b1, 1'b1, 8'h10);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 0, {7'd0, b1}, 8'h01);
    chk("pre_rst_data", 0, d1, 8'h11);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid1", 0, {7'd0, v1}, 8'h00);
    chk("arst_data1",  0, d1, 8'h00);
    chk("arst_busy1",  0, {7'd0, b1}, 8'h00);
    chk("arst_data2",  0, d2, 8'h00);
    chk("arst_busy2",  0, {7'd0, b2}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stale_v1", k, {7'd0, v1}, 8'h00);
      chk("stale_v2", k, {7'd0, v2}, 8'h00);
      chk("stale_b1", k, {7'd0, b1}, 8'h00);
    end
    drive(1'b1, 1'b0, 8'h03);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    chk("post_v1_early", 0, {7'd0, v1}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("post_v1", 0, {7'd0, v1}, 8'h01);
    chk("post_d1", 0, d1, 8'h04);
    chk("post_v2_early", 0, {7'd0, v2}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("post_v2", 0, {7'd0, v2}, 8'h01);
    chk("post_d2", 0, d2, 8'h04);
    chk("post_v1_off", 0, {7'd0, v1}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
